// File: rtl/seq_bool_waveform_pipe.sv
// seq_bool_waveform_pipe
// Per-bit sequential boolean function of an NBITS-wide input. The function is
// one of invert, pass, rise, fall, change or toggle. The result is delayed
// through a DEPTH-stage register pipeline that stalls as a whole when en is low.
// f_valid rises once DEPTH enabled edges have passed since reset, which is when
// f first carries a result computed from a real captured sample.
module seq_bool_waveform_pipe #(
  parameter int NBITS = 8,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [NBITS-1:0] a,
  output logic [NBITS-1:0] f,
  output logic             f_valid
);

  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [2:0] MODE_INV    = 3'd0;
  localparam logic [2:0] MODE_PASS   = 3'd1;
  localparam logic [2:0] MODE_RISE   = 3'd2;
  localparam logic [2:0] MODE_FALL   = 3'd3;
  localparam logic [2:0] MODE_CHANGE = 3'd4;
  localparam logic [2:0] MODE_TOGGLE = 3'd5;

  logic [NBITS-1:0] stage_p [DEPTH];
  logic [NBITS-1:0] a_prev;
  logic [NBITS-1:0] tgl;
  logic [CW-1:0]    fill_cnt;
  logic [NBITS-1:0] g;
  logic [NBITS-1:0] tgl_next;

  // Function of the current sample. Edge modes compare against the previous
  // captured a, which is tracked in every mode.
  always_comb begin
    g        = '0;
    tgl_next = tgl ^ a;
    case (mode)
      MODE_INV:    g = ~a;
      MODE_PASS:   g = a;
      MODE_RISE:   g = a & ~a_prev;
      MODE_FALL:   g = ~a & a_prev;
      MODE_CHANGE: g = a ^ a_prev;
      MODE_TOGGLE: g = tgl_next;
      default:     g = '0;
    endcase
  end

  // Capture, shift and fill tracking. Reset clears everything and beats en.
  // en=0 freezes all state.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int k = 0; k < DEPTH; k++) begin
        stage_p[k] <= '0;
      end
      a_prev   <= '0;
      tgl      <= '0;
      fill_cnt <= '0;
    end else if (en) begin
      // stage 1: capture the function result
      stage_p[0] <= g;
      // stages 2..DEPTH: shift toward f
      for (int k = 1; k < DEPTH; k++) begin
        stage_p[k] <= stage_p[k-1];
      end
      a_prev <= a;
      if (mode == MODE_TOGGLE) begin
        tgl <= tgl_next;
      end
      if (fill_cnt != CW'(DEPTH)) begin
        fill_cnt <= fill_cnt + CW'(1);
      end
    end
  end

  assign f       = stage_p[DEPTH-1];
  assign f_valid = (fill_cnt == CW'(DEPTH));

endmodule

// File: tb/tb_seq_bool_waveform_pipe.sv
// Bench for seq_bool_waveform_pipe. Four instances share one stimulus stream:
// NBITS=1/DEPTH=1, and NBITS=8 with DEPTH=1, 2 and 3. The reference model keeps
// the history of function results captured since reset. The output of a
// DEPTH-D pipe is the D-th most recent entry, or 0 while fewer than D exist.
module tb_seq_bool_waveform_pipe;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       en;
  logic [2:0] mode;
  logic [7:0] a;

  logic [0:0] f_n1;
  logic       v_n1;
  logic [7:0] f_d1, f_d2, f_d3;
  logic       v_d1, v_d2, v_d3;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [7:0] m_prev;
  logic [7:0] m_tgl;
  logic [7:0] hist[$];

  always #5 clk = ~clk;

  seq_bool_waveform_pipe #(.NBITS(1), .DEPTH(1)) u_n1 (
    .clk(clk), .reset_n(reset_n), .en(en), .mode(mode), .a(a[0]),
    .f(f_n1), .f_valid(v_n1));
  seq_bool_waveform_pipe #(.NBITS(8), .DEPTH(1)) u_d1 (
    .clk(clk), .reset_n(reset_n), .en(en), .mode(mode), .a(a),
    .f(f_d1), .f_valid(v_d1));
  seq_bool_waveform_pipe #(.NBITS(8), .DEPTH(2)) u_d2 (
    .clk(clk), .reset_n(reset_n), .en(en), .mode(mode), .a(a),
    .f(f_d2), .f_valid(v_d2));
  seq_bool_waveform_pipe #(.NBITS(8), .DEPTH(3)) u_d3 (
    .clk(clk), .reset_n(reset_n), .en(en), .mode(mode), .a(a),
    .f(f_d3), .f_valid(v_d3));

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_f(input int d);
    if (hist.size() >= d) return hist[hist.size() - d];
    return 8'h00;
  endfunction

  function automatic logic [7:0] exp_v(input int d);
    return (hist.size() >= d) ? 8'h01 : 8'h00;
  endfunction

  task automatic check_all();
    chk("n1_f", {7'b0, f_n1}, {7'b0, exp_f(1)[0]});
    chk("n1_v", {7'b0, v_n1}, exp_v(1));
    chk("d1_f", f_d1, exp_f(1));
    chk("d1_v", {7'b0, v_d1}, exp_v(1));
    chk("d2_f", f_d2, exp_f(2));
    chk("d2_v", {7'b0, v_d2}, exp_v(2));
    chk("d3_f", f_d3, exp_f(3));
    chk("d3_v", {7'b0, v_d3}, exp_v(3));
  endtask

  // Apply one clock's worth of inputs, advance the model, then check all pipes.
  task automatic step(input logic rn, input logic e, input logic [2:0] m, input logic [7:0] av);
    logic [7:0] gv;
    reset_n = rn;
    en      = e;
    mode    = m;
    a       = av;
    @(posedge clk);
    if (!rn) begin
      hist.delete();
      m_prev = 8'h00;
      m_tgl  = 8'h00;
    end else if (e) begin
      case (m)
        3'd0: gv = ~av;
        3'd1: gv = av;
        3'd2: gv = av & ~m_prev;
        3'd3: gv = ~av & m_prev;
        3'd4: gv = av ^ m_prev;
        3'd5: gv = m_tgl ^ av;
        default: gv = 8'h00;
      endcase
      if (m == 3'd5) m_tgl = m_tgl ^ av;
      m_prev = av;
      hist.push_back(gv);
    end
    #1;
    check_all();
  endtask

  initial begin
    m_prev = 8'h00;
    m_tgl  = 8'h00;
    reset_n = 1'b0; en = 1'b1; mode = 3'd0; a = 8'h00;

    // Reset state
    step(1'b0, 1'b1, 3'd0, 8'h00);
    step(1'b0, 1'b0, 3'd0, 8'hFF);

    // Inverter, single bit: a=1,0,0,1 -> f=0,1,1,0
    step(1'b1, 1'b1, 3'd0, 8'h01); chk("inv_e1", {7'b0, f_n1}, 8'h00); chk("inv_v1", {7'b0, v_n1}, 8'h01);
    step(1'b1, 1'b1, 3'd0, 8'h00); chk("inv_e2", {7'b0, f_n1}, 8'h01);
    step(1'b1, 1'b1, 3'd0, 8'h00); chk("inv_e3", {7'b0, f_n1}, 8'h01);
    step(1'b1, 1'b1, 3'd0, 8'h01); chk("inv_e4", {7'b0, f_n1}, 8'h00);

    // Pass through DEPTH=3
    step(1'b0, 1'b1, 3'd1, 8'h00);
    step(1'b1, 1'b1, 3'd1, 8'h11); chk("pass_v1", {7'b0, v_d3}, 8'h00);
    step(1'b1, 1'b1, 3'd1, 8'h22); chk("pass_v2", {7'b0, v_d3}, 8'h00);
    step(1'b1, 1'b1, 3'd1, 8'h33); chk("pass_e3", f_d3, 8'h11); chk("pass_v3", {7'b0, v_d3}, 8'h01);
    step(1'b1, 1'b1, 3'd1, 8'h44); chk("pass_e4", f_d3, 8'h22);
    step(1'b1, 1'b1, 3'd1, 8'h00); chk("pass_e5", f_d3, 8'h33);
    step(1'b1, 1'b1, 3'd1, 8'h00); chk("pass_e6", f_d3, 8'h44);

    // RISE / FALL / CHANGE, each from a fresh reset
    step(1'b0, 1'b1, 3'd2, 8'h00);
    step(1'b1, 1'b1, 3'd2, 8'h0F); chk("rise_1", f_d1, 8'h0F);
    step(1'b1, 1'b1, 3'd2, 8'hFF); chk("rise_2", f_d1, 8'hF0);
    step(1'b1, 1'b1, 3'd2, 8'hF0); chk("rise_3", f_d1, 8'h00);
    step(1'b0, 1'b1, 3'd3, 8'h00);
    step(1'b1, 1'b1, 3'd3, 8'h0F); chk("fall_1", f_d1, 8'h00);
    step(1'b1, 1'b1, 3'd3, 8'hFF); chk("fall_2", f_d1, 8'h00);
    step(1'b1, 1'b1, 3'd3, 8'hF0); chk("fall_3", f_d1, 8'h0F);
    step(1'b0, 1'b1, 3'd4, 8'h00);
    step(1'b1, 1'b1, 3'd4, 8'h0F); chk("chg_1", f_d1, 8'h0F);
    step(1'b1, 1'b1, 3'd4, 8'hFF); chk("chg_2", f_d1, 8'hF0);
    step(1'b1, 1'b1, 3'd4, 8'hF0); chk("chg_3", f_d1, 8'h0F);

    // TOGGLE through DEPTH=2: g=01,00,03,03
    step(1'b0, 1'b1, 3'd5, 8'h00);
    step(1'b1, 1'b1, 3'd5, 8'h01); chk("tgl_1", f_d2, 8'h00);
    step(1'b1, 1'b1, 3'd5, 8'h01); chk("tgl_2", f_d2, 8'h01);
    step(1'b1, 1'b1, 3'd5, 8'h03); chk("tgl_3", f_d2, 8'h00);
    step(1'b1, 1'b1, 3'd5, 8'h00); chk("tgl_4", f_d2, 8'h03);
    step(1'b1, 1'b1, 3'd1, 8'h00); chk("tgl_5", f_d2, 8'h03);

    // Stall: capture AA, hold three cycles with a=55, then resume
    step(1'b0, 1'b1, 3'd1, 8'h00);
    step(1'b1, 1'b1, 3'd1, 8'hAA); chk("stall_v0", {7'b0, v_d2}, 8'h00);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 3'd1, 8'h55);
      chk("stall_f", f_d2, 8'h00);
      chk("stall_v", {7'b0, v_d2}, 8'h00);
      chk("stall_d1", f_d1, 8'hAA);
    end
    step(1'b1, 1'b1, 3'd4, 8'hAA); chk("resume_f", f_d2, 8'hAA); chk("resume_chg", f_d1, 8'h00);

    // Mid-stream reset with DEPTH=3 full, then reserved mode refill
    step(1'b0, 1'b1, 3'd1, 8'h00);
    step(1'b1, 1'b1, 3'd1, 8'h5A);
    step(1'b1, 1'b1, 3'd1, 8'hA5);
    step(1'b1, 1'b1, 3'd1, 8'h3C); chk("full_f", f_d3, 8'h5A);
    step(1'b0, 1'b1, 3'd1, 8'hFF); chk("mrst_f", f_d3, 8'h00); chk("mrst_v", {7'b0, v_d3}, 8'h00);
    step(1'b1, 1'b1, 3'd6, 8'hFF); chk("rsv_v1", {7'b0, v_d3}, 8'h00);
    step(1'b1, 1'b1, 3'd7, 8'hFF); chk("rsv_v2", {7'b0, v_d3}, 8'h00);
    step(1'b1, 1'b1, 3'd6, 8'hFF); chk("rsv_v3", {7'b0, v_d3}, 8'h01); chk("rsv_f", f_d3, 8'h00);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 39) != 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
           3'($urandom_range(0, 7)),
           8'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_bool_waveform_pipe.md
Name: seq_bool_waveform_pipe

Overview:
Parametrised successor to the single-bit registered inverter.
- Applies one selectable per-bit sequential boolean function (invert, pass, edge detect, change detect, toggle) to an NBITS-wide input.
- Delays the result through a DEPTH-stage register pipeline with a global enable (stall).
- Flags when the output holds a sample derived from real input via f_valid.
- Used as a configurable waveform-generation/conditioning stage in the sequential-logic problem set.

Parameters:
NBITS, 8, width of a and f (>=1)
DEPTH, 1, number of register stages from a to f (>=1); DEPTH=1 gives single-cycle latency

Ports:
clk      input   1      clock; all state updates on posedge
reset_n  input   1      synchronous, active-low reset
en       input   1      advance enable; 0 freezes all state
mode     input   3      function select, sampled with a
a        input   NBITS  data input
f        output  NBITS  registered function output, DEPTH cycles after capture
f_valid  output  1      1 when f holds a function of a captured sample

Behaviour:
- Reset: reset_n is sampled at posedge clk only.
  - When low, clear all state: pipeline stages=0, a_prev=0, tgl=0, fill count=0, so f=0 and f_valid=0 after that edge.
  - Reset wins over en.
  - Reset mid-operation discards all in-flight samples.
- Capture: on a posedge with reset_n=1 and en=1, compute g from the current a, mode, a_prev and tgl, and load g into stage 1.
  - Stage k loads stage k-1 for k=2..DEPTH; f = stage DEPTH.
  - In the same edge, a_prev<=a, and tgl<=tgl^a when mode=5 (tgl unchanged in other modes).
- Modes, per bit:
  - 0 INV: g=~a
  - 1 PASS: g=a
  - 2 RISE: g=a&~a_prev
  - 3 FALL: g=~a&a_prev
  - 4 CHANGE: g=a^a_prev
  - 5 TOGGLE: g=tgl^a, i.e. the new tgl value
  - 6,7 reserved: g=0
- Latency: a sample captured at edge N appears on f after edge N+DEPTH-1, counting only en=1 edges.
  - DEPTH=1: f after edge N equals ~a sampled at edge N (mode 0).
- Stall: en=0 holds every stage, a_prev, tgl, the fill count and f_valid unchanged. a and mode are ignored that cycle.
- Mode change: takes effect on the sample captured that edge. In-flight samples keep the mode they were captured with. a_prev is tracked in all modes, so an edge mode selected mid-stream compares against the true previous captured a.
- First sample after reset: a_prev=0, so RISE reports every 1 bit and FALL reports 0.
- f_valid: fill counter of width clog2(DEPTH+1).
  - Increments on each en=1 edge and saturates at DEPTH.
  - f_valid=(count==DEPTH).
  - Reserved-mode samples still count as valid (f=0).
- No combinational path from any input to f or f_valid.

Test Plan:
- NBITS=1, DEPTH=1, mode=0, en=1, reset_n=0 for 1 cycle then a=1,0,0,1 on successive edges -> f=0,1,1,0 one edge after each capture; f_valid=1 from the first capture edge.
- NBITS=8, DEPTH=3, mode=1, a=0x11,0x22,0x33,0x44 -> f_valid=0 after edges 1-2; f=0x11 with f_valid=1 after edge 3, then 0x22, 0x33, 0x44.
- NBITS=8, DEPTH=1, mode=2 (RISE), a=0x0F,0xFF,0xF0 -> f=0x0F,0xF0,0x00. Repeat with mode=3 (FALL) -> f=0x00,0x00,0x0F. Repeat with mode=4 (CHANGE) -> f=0x0F,0xF0,0x0F.
- DEPTH=2, mode=5 (TOGGLE), a=0x01,0x01,0x03,0x00 -> g=0x01,0x00,0x03,0x03; f shows these two edges after each capture.
- DEPTH=2, mode=1, a=0xAA captured, en=0 for 3 cycles with a=0x55 -> f and f_valid frozen, a_prev stays 0xAA; en=1 resumes and 0xAA reaches f on the next enabled edge.
- Mid-stream reset: DEPTH=3 with pipeline full, assert reset_n=0 with en=1 -> f=0 and f_valid=0 after that edge; the next three enabled edges rebuild f_valid. Mode 6 input 0xFF -> f=0x00 with f_valid=1 once full.
